data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram.sv | 116 +++++++++++
 tb/tb_data_ram.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// data_ram: single-port word RAM with one-cycle registered read.
// After reset the whole array is swept to zero before it accepts accesses.
// While the sweep runs, writes are ignored and memresult reads 0.
// In RUN, every cycle reads memaddr. A write in the same cycle is returned
// write-first.
// Optional macro RAM_PARITY_EN adds one even-parity bit per word and a
// sticky parity_err flag. inj_par inverts the stored parity bit for test.
module data_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] memaddr,
    input  logic              writemem,
    input  logic [DATA_W-1:0] writememdata,
    input  logic              inj_par,
    output logic [DATA_W-1:0] memresult,
    output logic              ready,
    output logic              parity_err
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int STORE_W = DATA_W + 1;
`else
    localparam int STORE_W = DATA_W;
`endif

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     clr_ptr_q, clr_ptr_d;    // MSB set once the sweep is done
    logic [DATA_W-1:0]   memresult_q, memresult_d;
    logic                parity_err_q, parity_err_d;

    logic [STORE_W-1:0]  mem_q [DEPTH];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [STORE_W-1:0]  wr_word;
    logic [STORE_W-1:0]  wr_store;   // incoming data as it would be stored
    logic [STORE_W-1:0]  rd_word;    // word seen by this cycle's read (write-first)

    // Build the stored form of the write data (data plus parity bit, if enabled).
    always_comb begin
`ifdef RAM_PARITY_EN
        wr_store = {(^writememdata) ^ inj_par, writememdata};
`else
        wr_store = writememdata;
`endif
        rd_word = writemem ? wr_store : mem_q[memaddr];
    end

`ifndef RAM_PARITY_EN
    logic unused_inj_par;
    assign unused_inj_par = inj_par;
`endif

    // Next state, clear sweep, write port and read result.
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        memresult_d  = memresult_q;
        parity_err_d = parity_err_q;
        wr_en        = 1'b0;
        wr_addr      = memaddr;
        wr_word      = wr_store;
        case (state_q)
            CLEAR: begin
                wr_en       = 1'b1;
                wr_addr     = clr_ptr_q[ADDR_W-1:0];
                wr_word     = '0;
                clr_ptr_d   = clr_ptr_q + 1'b1;
                memresult_d = '0;
                if (clr_ptr_d[ADDR_W]) state_d = RUN;
            end
            RUN: begin
                wr_en       = writemem;
                memresult_d = rd_word[DATA_W-1:0];
`ifdef RAM_PARITY_EN
                // Even parity over data plus stored bit must be zero.
                parity_err_d = parity_err_q | (^rd_word);
`endif
            end
            default: state_d = CLEAR;
        endcase
        // Reset takes priority over any access.
        if (reset) wr_en = 1'b0;
    end

    // State registers. The synchronous reset restarts the sweep.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_ptr_q    <= '0;
            memresult_q  <= '0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            memresult_q  <= memresult_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Storage array write port. The array has no reset; the sweep clears it.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_addr] <= wr_word;
    end

    assign memresult  = memresult_q;
    assign ready      = (state_q == RUN);
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram. Expected read data is queued when an address
// is presented, then popped and compared one cycle later.
module tb_data_ram;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] memaddr;
    logic              writemem;
    logic [DATA_W-1:0] writememdata;
    logic              inj_par;
    logic [DATA_W-1:0] memresult;
    logic              ready;
    logic              parity_err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q [$];
    string             tag_q [$];

    data_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .memaddr      (memaddr),
        .writemem     (writemem),
        .writememdata (writememdata),
        .inj_par      (inj_par),
        .memresult    (memresult),
        .ready        (ready),
        .parity_err   (parity_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, queue expected read data, clock, then compare.
    task automatic cyc(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic inj, input logic [DATA_W-1:0] exp, input string tag);
        logic [DATA_W-1:0] e;
        string t;
        writemem     = we;
        memaddr      = a;
        writememdata = d;
        inj_par      = inj;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, memresult, e);
    endtask

    // Sweep phase: writes attempted with junk data must not land; ready rises
    // only after the full array has been cleared.
    task automatic sweep(input string tag);
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b1, ADDR_W'(i), 32'hFFFF_FFFF, 1'b0, 32'h0, {tag, "_memresult"});
            chk({tag, "_ready"}, {31'b0, ready}, {31'b0, (i == DEPTH)});
        end
    endtask

    initial begin
        reset        = 1'b1;
        memaddr      = '0;
        writemem     = 1'b0;
        writememdata = '0;
        inj_par      = 1'b0;

        // Reset state.
        @(posedge clock);
        #1;
        chk("rst_memresult", memresult, 32'h0);
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_parity_err", {31'b0, parity_err}, 32'h0);
        reset = 1'b0;

        sweep("clear1");

        // Nothing written during the sweep survived.
        cyc(1'b0, 10'd0,    '0, 1'b0, 32'h0, "post_clear_a0");
        cyc(1'b0, 10'd5,    '0, 1'b0, 32'h0, "post_clear_a5");
        cyc(1'b0, 10'd1023, '0, 1'b0, 32'h0, "post_clear_a1023");

        // Write then read with exact one-cycle latency.
        cyc(1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, "wr5_first");
        cyc(1'b0, 10'd6, '0, 1'b0, 32'h0, "rd6");
        cyc(1'b0, 10'd5, '0, 1'b0, 32'hDEAD_BEEF, "rd5");

        // Same-cycle write/read returns new data.
        cyc(1'b1, 10'd9, 32'h1234_5678, 1'b0, 32'h1234_5678, "wr9_first");
        cyc(1'b0, 10'd9, '0, 1'b0, 32'h1234_5678, "rd9");

        // Top and bottom address, no aliasing.
        cyc(1'b1, 10'd1023, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, "wr1023");
        cyc(1'b1, 10'd0,    32'h0000_0001, 1'b0, 32'h0000_0001, "wr0");
        cyc(1'b0, 10'd1023, '0, 1'b0, 32'hA5A5_A5A5, "rd1023");
        cyc(1'b0, 10'd0,    '0, 1'b0, 32'h0000_0001, "rd0");
        cyc(1'b0, 10'd5,    '0, 1'b0, 32'hDEAD_BEEF, "rd5_again");
        chk("clean_parity_err", {31'b0, parity_err}, 32'h0);

        // Injected parity error on address 7.
        cyc(1'b1, 10'd7, 32'h0000_0001, 1'b1, 32'h0000_0001, "wr7_inj");
        cyc(1'b0, 10'd7, '0, 1'b0, 32'h0000_0001, "rd7_inj");
`ifdef RAM_PARITY_EN
        chk("par_err_set", {31'b0, parity_err}, 32'h1);
        cyc(1'b0, 10'd5, '0, 1'b0, 32'hDEAD_BEEF, "rd5_after_inj");
        chk("par_err_sticky", {31'b0, parity_err}, 32'h1);
`else
        chk("par_err_off", {31'b0, parity_err}, 32'h0);
        cyc(1'b0, 10'd5, '0, 1'b0, 32'hDEAD_BEEF, "rd5_after_inj");
        chk("par_err_off_hold", {31'b0, parity_err}, 32'h0);
`endif

        // Reset in RUN restarts the sweep and loses contents.
        cyc(1'b1, 10'd3, 32'h0000_0077, 1'b0, 32'h0000_0077, "wr3");
        cyc(1'b0, 10'd3, '0, 1'b0, 32'h0000_0077, "rd3");
        reset    = 1'b1;
        writemem = 1'b1;
        memaddr  = 10'd3;
        writememdata = 32'h5555_5555;
        @(posedge clock);
        #1;
        chk("rst2_ready", {31'b0, ready}, 32'h0);
        chk("rst2_memresult", memresult, 32'h0);
        chk("rst2_parity_err", {31'b0, parity_err}, 32'h0);
        reset = 1'b0;

        sweep("clear2");
        cyc(1'b0, 10'd3, '0, 1'b0, 32'h0, "rd3_after_reclear");
        cyc(1'b0, 10'd5, '0, 1'b0, 32'h0, "rd5_after_reclear");
        cyc(1'b0, 10'd7, '0, 1'b0, 32'h0, "rd7_after_reclear");
        chk("parity_err_after_reclear", {31'b0, parity_err}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
